// File: rtl/hamming_spi_tx_ctrl.sv
// ---------------------------------------------------------------------------
// hamming_spi_tx_ctrl
//
// Sequencer and SPI mode-0 transmitter for the serial SECDED encoder
// (hamming_enc). One 11-bit word is taken per valid/ready handshake and held
// on enc_data. The encoder step index enc_state then walks 0..14. On the
// posedge where step 14 is observed, the 16-bit packet is captured and sent
// MSB-first on the SPI link. An optional idle gap with cs_n high follows.
//
// Parameters
//   CLK_DIV     clk cycles per SCLK half-period (>= 1)
//   GAP_CYCLES  idle clk cycles with cs_n high after each frame (>= 0)
//
// Ports
//   clk, rst_n   clock; asynchronous active-low reset
//   in_valid     host word valid
//   in_data      host word (11 bits)
//   in_ready     word can be accepted (IDLE only; low while in reset)
//   enc_data     word driven to the encoder, stable from accept to next accept
//   enc_state    encoder step index (15 = idle/clear)
//   enc_packet   16-bit encoded packet returned by the encoder
//   spi_sclk     SPI clock, idles low
//   spi_mosi     SPI data, MSB first
//   spi_cs_n     SPI chip select, active low
//   busy         high in every state except IDLE
//   pkt_count    completed frames, wraps at 16'hFFFF
// ---------------------------------------------------------------------------
module hamming_spi_tx_ctrl #(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [10:0] in_data,
    output logic        in_ready,
    output logic [10:0] enc_data,
    output logic [3:0]  enc_state,
    input  logic [15:0] enc_packet,
    output logic        spi_sclk,
    output logic        spi_mosi,
    output logic        spi_cs_n,
    output logic        busy,
    output logic [15:0] pkt_count
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    // When GAP_CYCLES is 0 the GAP state is never entered; the value is unused.
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ENCODE = 2'd1,
        S_SHIFT  = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t            state_q,     state_d;
    logic [10:0]       enc_data_q,  enc_data_d;
    logic [3:0]        enc_state_q, enc_state_d;
    logic              sclk_q,      sclk_d;
    logic              mosi_q,      mosi_d;
    logic              cs_n_q,      cs_n_d;
    logic [15:0]       pkt_count_q, pkt_count_d;
    // Bit 15 of the packet goes straight onto mosi at capture, so only the
    // remaining 15 bits need to be held for shifting.
    logic [14:0]       shift_q,     shift_d;
    logic [DIV_W-1:0]  div_cnt_q,   div_cnt_d;
    logic [3:0]        bit_cnt_q,   bit_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q,   gap_cnt_d;

    always_comb begin
        state_d     = state_q;
        enc_data_d  = enc_data_q;
        enc_state_d = enc_state_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        cs_n_d      = cs_n_q;
        pkt_count_d = pkt_count_q;
        shift_d     = shift_q;
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                enc_state_d = 4'd15;
                if (in_valid) begin
                    enc_data_d  = in_data;
                    enc_state_d = 4'd0;
                    state_d     = S_ENCODE;
                end
            end

            S_ENCODE: begin
                // Capture on step 14: both parity latches in the encoder have
                // been loaded on the preceding negedges. Moving to 15 only
                // after capture keeps the encoder from clearing early.
                if (enc_state_q == 4'd14) begin
                    shift_d     = enc_packet[14:0];
                    mosi_d      = enc_packet[15];
                    enc_state_d = 4'd15;
                    cs_n_d      = 1'b0;
                    sclk_d      = 1'b0;
                    div_cnt_d   = '0;
                    bit_cnt_d   = 4'd0;
                    state_d     = S_SHIFT;
                end else begin
                    enc_state_d = enc_state_q + 4'd1;
                end
            end

            S_SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // Falling edge: next bit goes out (mode 0 changes data
                        // while SCLK is low).
                        sclk_d = 1'b0;
                        if (bit_cnt_q == 4'd15) begin
                            cs_n_d      = 1'b1;
                            mosi_d      = 1'b0;
                            pkt_count_d = pkt_count_q + 16'd1;
                            gap_cnt_d   = '0;
                            state_d     = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                        end else begin
                            mosi_d    = shift_q[14];
                            shift_d   = {shift_q[13:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end

            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            enc_data_q  <= '0;
            enc_state_q <= 4'd15;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            pkt_count_q <= '0;
            shift_q     <= '0;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            enc_data_q  <= enc_data_d;
            enc_state_q <= enc_state_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            cs_n_q      <= cs_n_d;
            pkt_count_q <= pkt_count_d;
            shift_q     <= shift_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    // in_ready is gated by rst_n so it reads low while reset is held.
    assign in_ready  = rst_n && (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign enc_data  = enc_data_q;
    assign enc_state = enc_state_q;
    assign spi_sclk  = sclk_q;
    assign spi_mosi  = mosi_q;
    assign spi_cs_n  = cs_n_q;
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_hamming_spi_tx_ctrl.sv
// Bench for hamming_spi_tx_ctrl. Instance 0 uses the default parameters,
// instance 1 uses CLK_DIV=1, GAP_CYCLES=0. Each instance is paired with a
// behavioural serial encoder (parity latched on negedge at steps 6 and 14,
// cleared at step 15). Stimulus pushes expected packets into a per-instance
// queue; a per-instance monitor reassembles SPI frames and pops/compares.
module tb_hamming_spi_tx_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [1:0]       in_valid;
    logic [1:0][10:0] in_data;
    logic [1:0]       in_ready;
    logic [1:0][10:0] enc_data;
    logic [1:0][3:0]  enc_state;
    logic [1:0][15:0] enc_packet;
    logic [1:0]       sclk;
    logic [1:0]       mosi;
    logic [1:0]       cs_n;
    logic [1:0]       busy;
    logic [1:0][15:0] pkt_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] exp_q [2][$];
    int          exp_cnt [2];
    bit          cnt_known [2];

    always @(posedge clk) cyc <= cyc + 1;

    hamming_spi_tx_ctrl #(.CLK_DIV(2), .GAP_CYCLES(2)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_data(in_data[0]),
        .in_ready(in_ready[0]), .enc_data(enc_data[0]), .enc_state(enc_state[0]),
        .enc_packet(enc_packet[0]), .spi_sclk(sclk[0]), .spi_mosi(mosi[0]),
        .spi_cs_n(cs_n[0]), .busy(busy[0]), .pkt_count(pkt_count[0])
    );

    hamming_spi_tx_ctrl #(.CLK_DIV(1), .GAP_CYCLES(0)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_data(in_data[1]),
        .in_ready(in_ready[1]), .enc_data(enc_data[1]), .enc_state(enc_state[1]),
        .enc_packet(enc_packet[1]), .spi_sclk(sclk[1]), .spi_mosi(mosi[1]),
        .spi_cs_n(cs_n[1]), .busy(busy[1]), .pkt_count(pkt_count[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Hamming(15,11) parity: data bit i is d(i+1), codeword positions 3,5,6,7,9..15.
    function automatic logic [3:0] lowpar(input logic [10:0] d);
        lowpar = {^(d & 11'h7F0), ^(d & 11'h78E), ^(d & 11'h66D), ^(d & 11'h55B)};
    endfunction

    function automatic logic [15:0] golden(input logic [10:0] d);
        logic [3:0] p;
        p = lowpar(d);
        golden = {d, p, ^{d, p}};
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int CD = (gi == 0) ? 2 : 1;
        logic [3:0] lp;
        logic       ov;

        // Behavioural serial encoder.
        always @(negedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lp <= 4'd0;
                ov <= 1'b0;
            end else if (enc_state[gi] == 4'd15) begin
                lp <= 4'd0;
                ov <= 1'b0;
            end else if (enc_state[gi] == 4'd6) begin
                lp <= lowpar(enc_data[gi]);
            end else if (enc_state[gi] == 4'd14) begin
                ov <= ^{enc_data[gi], lp};
            end
        end
        assign enc_packet[gi] = {enc_data[gi], lp, ov};

        // SPI frame monitor, sampled on negedge.
        logic        prev_sclk;
        logic        prev_cs;
        logic [15:0] sh;
        int          nbits;
        int          lowcyc;

        always @(negedge clk) begin
            if (!rst_n) begin
                prev_sclk = 1'b0;
                prev_cs   = 1'b1;
                nbits     = 0;
                lowcyc    = 0;
                sh        = 16'h0;
            end else begin
                if (!cs_n[gi]) lowcyc++;
                if (!cs_n[gi] && sclk[gi] && !prev_sclk) begin
                    sh = {sh[14:0], mosi[gi]};
                    nbits++;
                end
                if (!prev_cs && cs_n[gi]) begin
                    if (exp_q[gi].size() == 0) begin
                        check("unexpected_frame", 32'd1, 32'd0);
                    end else begin
                        logic [15:0] e;
                        e = exp_q[gi].pop_front();
                        check("packet", {16'h0, sh}, {16'h0, e});
                    end
                    check("bits_per_frame", nbits, 32'd16);
                    check("cs_low_cycles", lowcyc, 32 * CD);
                    check("sclk_idle_after_frame", {31'h0, sclk[gi]}, 32'd0);
                    exp_cnt[gi]++;
                    if (cnt_known[gi])
                        check("pkt_count", {16'h0, pkt_count[gi]}, exp_cnt[gi]);
                    $display("frame inst=%0d bits=%0d data=%04h cs_low=%0d cnt=%0d",
                             gi, nbits, sh, lowcyc, pkt_count[gi]);
                    nbits  = 0;
                    lowcyc = 0;
                end
                if (cs_n[gi] && sclk[gi])
                    check("sclk_high_while_cs_high", 32'd1, 32'd0);
                if (in_ready[gi] == busy[gi])
                    check("in_ready_only_idle", {31'h0, in_ready[gi]}, {31'h0, ~busy[gi]});
                prev_sclk = sclk[gi];
                prev_cs   = cs_n[gi];
            end
        end
    end

    // Offer a word; returns the cycle number of the accepting posedge (-1 on timeout).
    task automatic send(input int k, input logic [10:0] d, input logic [15:0] e,
                        input bit hold, output int acc);
        int w;
        w = 0;
        @(negedge clk);
        in_valid[k] = 1'b1;
        in_data[k]  = d;
        while (!in_ready[k] && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready[k]) begin
            check("accept_timeout", 32'd1, 32'd0);
            in_valid[k] = 1'b0;
            acc = -1;
        end else begin
            exp_q[k].push_back(e);
            acc = cyc;
            @(posedge clk);
            #1;
            if (!hold) in_valid[k] = 1'b0;
            $display("accept inst=%0d data=%03h expect=%04h cycle=%0d", k, d, e, acc);
        end
    endtask

    task automatic wait_idle(input int k);
        int w;
        w = 0;
        while ((busy[k] || exp_q[k].size() != 0) && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 1000) check("idle_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int a1, a2, a3;
        rst_n       = 1'b0;
        in_valid    = '0;
        in_data     = '0;
        cnt_known[0] = 1'b1;
        cnt_known[1] = 1'b1;
        exp_cnt[0]  = 0;
        exp_cnt[1]  = 0;

        // Reset state.
        #23;
        check("rst_in_ready", {31'h0, in_ready[0]}, 32'd0);
        check("rst_cs_n", {31'h0, cs_n[0]}, 32'd1);
        check("rst_sclk", {31'h0, sclk[0]}, 32'd0);
        check("rst_mosi", {31'h0, mosi[0]}, 32'd0);
        check("rst_enc_state", {28'h0, enc_state[0]}, 32'd15);
        check("rst_enc_data", {21'h0, enc_data[0]}, 32'd0);
        check("rst_busy", {31'h0, busy[0]}, 32'd0);
        check("rst_pkt_count", {16'h0, pkt_count[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {31'h0, in_ready[0]}, 32'd1);

        // 1: all-zero word.
        send(0, 11'h000, 16'h0000, 1'b0, a1);
        wait_idle(0);

        // 2: golden packets and the enc_state trace.
        check("enc_state_idle", {28'h0, enc_state[0]}, 32'd15);
        send(0, 11'h7FF, 16'hFFFF, 1'b0, a1);
        check("enc_data_held", {21'h0, enc_data[0]}, 32'h7FF);
        for (int i = 0; i <= 15; i++) begin
            check("enc_state_trace", {28'h0, enc_state[0]}, i);
            if (i == 15) check("cs_fall_at_capture", {31'h0, cs_n[0]}, 32'd0);
            else         check("cs_high_in_encode", {31'h0, cs_n[0]}, 32'd1);
            @(posedge clk);
            #1;
        end
        wait_idle(0);
        send(0, 11'h2A5, 16'h54BA, 1'b0, a1);
        wait_idle(0);

        // 3: in_valid held across three words; accepts spaced 16+64+2 cycles.
        send(0, 11'h123, golden(11'h123), 1'b1, a1);
        send(0, 11'h456, golden(11'h456), 1'b1, a2);
        send(0, 11'h789, golden(11'h789), 1'b0, a3);
        check("accept_spacing_1", a2 - a1, 32'd82);
        check("accept_spacing_2", a3 - a2, 32'd82);
        wait_idle(0);
        repeat (100) @(negedge clk);

        // 4: reset during SHIFT bit 7 abandons the frame.
        send(0, 11'h3C5, golden(11'h3C5), 1'b0, a1);
        repeat (44) @(posedge clk);
        #2;
        check("mid_frame_cs_low", {31'h0, cs_n[0]}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("async_rst_cs_n", {31'h0, cs_n[0]}, 32'd1);
        check("async_rst_sclk", {31'h0, sclk[0]}, 32'd0);
        check("async_rst_enc_state", {28'h0, enc_state[0]}, 32'd15);
        check("async_rst_busy", {31'h0, busy[0]}, 32'd0);
        check("async_rst_in_ready", {31'h0, in_ready[0]}, 32'd0);
        exp_q[0].delete();
        cnt_known[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 11'h0F0, golden(11'h0F0), 1'b0, a1);
        wait_idle(0);

        // 5: CLK_DIV=1, GAP_CYCLES=0 instance.
        send(1, 11'h2A5, 16'h54BA, 1'b0, a1);
        send(1, 11'h7FF, 16'hFFFF, 1'b0, a2);
        check("fast_accept_spacing", a2 - a1, 32'd48);
        wait_idle(1);

        // 6: in_data churns after accept.
        send(0, 11'h5A3, golden(11'h5A3), 1'b0, a1);
        for (int i = 0; i < 90; i++) begin
            @(negedge clk);
            in_data[0] = 11'($urandom);
            if (i == 40) check("enc_data_stable", {21'h0, enc_data[0]}, 32'h5A3);
        end
        wait_idle(0);

        repeat (50) @(negedge clk);
        check("queue0_empty", exp_q[0].size(), 32'd0);
        check("queue1_empty", exp_q[1].size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
